// File: rtl/start_gen_pkg.sv
// Shared constants and state encoding for the start-pulse generator and the
// 5-tap sequencer chain it drives.
package start_gen_pkg;

    localparam int CHAIN_DEPTH_DEF = 5;
    localparam int SPACING_DEF     = 5;
    localparam int TIMEOUT_DEF     = 16;
    localparam int CNT_W_DEF       = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FIRE  = 3'd1,
        GAP   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/start_pulse_gen_if.sv
// Handshake, chain and status signals between the generator and its user.
interface start_pulse_gen_if
    import start_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             req;
    logic [CNT_W-1:0] burst_len;
    logic             abort;
    logic             echo;
    logic             start;
    logic             busy;
    logic             ack;
    logic             done;
    logic             timeout_err;
    logic [CNT_W-1:0] pulses_sent;

    modport master (
        output req, burst_len, abort, echo,
        input  start, busy, ack, done, timeout_err, pulses_sent
    );

    modport slave (
        input  req, burst_len, abort, echo,
        output start, busy, ack, done, timeout_err, pulses_sent
    );
endinterface

// File: rtl/start_pulse_gen_hold_timer.sv
// Loadable down-counter that stops at zero; load has priority over enable.
module hold_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/start_pulse_gen.sv
// Burst generator for the DFF sequencer chain: spaced single-cycle starts,
// echo accounting on the last tap, and a drain timeout.
module start_pulse_gen
    import start_gen_pkg::*;
#(
    parameter int CHAIN_DEPTH = CHAIN_DEPTH_DEF,
    parameter int SPACING     = SPACING_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    start_pulse_gen_if.slave  bus
);

    // Clamp to the legal ranges so a bad override cannot make an echo unreachable.
    localparam int GAP_CYCLES   = (SPACING < 2) ? 2 : SPACING;
    localparam int DRAIN_CYCLES = (TIMEOUT > CHAIN_DEPTH) ? TIMEOUT : CHAIN_DEPTH + 1;
    localparam int TMR_MAX      = (DRAIN_CYCLES > GAP_CYCLES) ? DRAIN_CYCLES : GAP_CYCLES;
    localparam int TMR_W        = $clog2(TMR_MAX);
    localparam int N_TMR        = 2;
    localparam int T_GAP        = 0;
    localparam int T_DRAIN      = 1;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] remaining_reg, remaining_next;
    logic [CNT_W-1:0] pulses_sent_reg, pulses_sent_next;
    logic [CNT_W-1:0] echo_cnt_reg, echo_cnt_next;
    logic             timeout_err_reg, timeout_err_next;
    logic             ack_reg, ack_next;
    logic             gap_load, drain_load;

    logic [N_TMR-1:0] tmr_load, tmr_en, tmr_zero;
    logic [TMR_W-1:0] tmr_val [N_TMR];

    assign tmr_load[T_GAP]   = gap_load;
    assign tmr_load[T_DRAIN] = drain_load;
    assign tmr_en[T_GAP]     = (state_reg == GAP);
    assign tmr_en[T_DRAIN]   = (state_reg == DRAIN);
    assign tmr_val[T_GAP]    = TMR_W'(GAP_CYCLES - 2);
    assign tmr_val[T_DRAIN]  = TMR_W'(DRAIN_CYCLES - 1);

    genvar gi;
    generate
        for (gi = 0; gi < N_TMR; gi++) begin : g_tmr
            hold_timer #(.W(TMR_W)) u_tmr (
                .clk      (clk),
                .reset    (reset),
                .load     (tmr_load[gi]),
                .load_val (tmr_val[gi]),
                .en       (tmr_en[gi]),
                .zero     (tmr_zero[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            remaining_reg   <= '0;
            pulses_sent_reg <= '0;
            echo_cnt_reg    <= '0;
            timeout_err_reg <= 1'b0;
            ack_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            remaining_reg   <= remaining_next;
            pulses_sent_reg <= pulses_sent_next;
            echo_cnt_reg    <= echo_cnt_next;
            timeout_err_reg <= timeout_err_next;
            ack_reg         <= ack_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        remaining_next   = remaining_reg;
        pulses_sent_next = pulses_sent_reg;
        echo_cnt_next    = echo_cnt_reg;
        timeout_err_next = timeout_err_reg;
        ack_next         = 1'b0;
        gap_load         = 1'b0;
        drain_load       = 1'b0;

        // Echo count saturates at the number of starts actually issued.
        if ((state_reg != IDLE) && bus.echo && (echo_cnt_reg < pulses_sent_reg)) begin
            echo_cnt_next = echo_cnt_reg + CNT_W'(1);
        end

        case (state_reg)
            IDLE: begin
                if (bus.req && !bus.abort) begin
                    remaining_next   = bus.burst_len;
                    pulses_sent_next = '0;
                    echo_cnt_next    = '0;
                    timeout_err_next = 1'b0;
                    ack_next         = 1'b1;
                    state_next       = (bus.burst_len == '0) ? DONE : FIRE;
                end
            end
            FIRE: begin
                remaining_next   = remaining_reg - CNT_W'(1);
                pulses_sent_next = pulses_sent_reg + CNT_W'(1);
                if (bus.abort) begin
                    state_next = DONE;
                end else if (remaining_reg > CNT_W'(1)) begin
                    state_next = GAP;
                    gap_load   = 1'b1;
                end else begin
                    state_next = DRAIN;
                    drain_load = 1'b1;
                end
            end
            GAP: begin
                if (bus.abort) begin
                    state_next = DONE;
                end else if (tmr_zero[T_GAP]) begin
                    state_next = FIRE;
                end
            end
            DRAIN: begin
                // An echo in the expiry cycle reloads the timer instead of timing out.
                if (bus.abort) begin
                    state_next = DONE;
                end else if (echo_cnt_next == pulses_sent_reg) begin
                    state_next = DONE;
                end else if (bus.echo) begin
                    drain_load = 1'b1;
                end else if (tmr_zero[T_DRAIN]) begin
                    timeout_err_next = 1'b1;
                    state_next       = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.start       = (state_reg == FIRE);
    assign bus.busy        = (state_reg != IDLE);
    assign bus.done        = (state_reg == DONE);
    assign bus.ack         = ack_reg;
    assign bus.timeout_err = timeout_err_reg;
    assign bus.pulses_sent = pulses_sent_reg;

endmodule

// File: tb/tb_start_pulse_gen.sv
// Directed bench: generator driving a 5-flop chain model whose last tap is fed back as echo.
module tb_start_pulse_gen;
    import start_gen_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       echo_en;
    logic [4:0] chain_reg;

    int n_vec = 0;
    int n_bad = 0;

    int start_cyc[$];
    int echo_cyc[$];
    int ack_cnt, ack_first, done_cyc, terr_at_ack;
    int w_busy, w_done, w_ack, w_echo, w_start;

    start_pulse_gen_if #(.CNT_W(8)) bus ();

    start_pulse_gen #(
        .CHAIN_DEPTH (5),
        .SPACING     (5),
        .CNT_W       (8),
        .TIMEOUT     (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) chain_reg <= '0;
        else       chain_reg <= {chain_reg[3:0], bus.start};
    end

    assign bus.echo = echo_en & chain_reg[4];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Called at a negedge (cycle 0); records event cycles relative to that point.
    task automatic run_burst(input int len, input int abort_at, input bit hold_req);
        start_cyc.delete();
        echo_cyc.delete();
        ack_cnt     = 0;
        ack_first   = -1;
        done_cyc    = -1;
        terr_at_ack = -1;
        bus.burst_len = 8'(len);
        bus.req       = 1'b1;
        for (int k = 1; k <= 60 && done_cyc < 0; k++) begin
            @(negedge clk);
            if (bus.ack === 1'b1) begin
                ack_cnt++;
                if (ack_first < 0) begin
                    ack_first   = k;
                    terr_at_ack = int'(bus.timeout_err);
                end
                if (!hold_req) bus.req = 1'b0;
            end
            if (bus.start === 1'b1) start_cyc.push_back(k);
            if (bus.echo === 1'b1)  echo_cyc.push_back(k);
            if (bus.done === 1'b1) begin
                done_cyc = k;
                bus.req  = 1'b0;
            end
            bus.abort = (k == abort_at);
        end
        bus.abort = 1'b0;
        bus.req   = 1'b0;
        $display("burst len=%0d: ack@%0d starts=%0d echoes=%0d done@%0d",
                 len, ack_first, start_cyc.size(), echo_cyc.size(), done_cyc);
    endtask

    task automatic watch(input int n);
        w_busy = 0; w_done = 0; w_ack = 0; w_echo = 0; w_start = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.busy  === 1'b1) w_busy++;
            if (bus.done  === 1'b1) w_done++;
            if (bus.ack   === 1'b1) w_ack++;
            if (bus.echo  === 1'b1) w_echo++;
            if (bus.start === 1'b1) w_start++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        echo_en       = 1'b1;
        bus.req       = 1'b0;
        bus.abort     = 1'b0;
        bus.burst_len = '0;
        repeat (3) @(negedge clk);
        check_val("rst_start", 32'(bus.start), 0);
        check_val("rst_busy", 32'(bus.busy), 0);
        check_val("rst_ack", 32'(bus.ack), 0);
        check_val("rst_done", 32'(bus.done), 0);
        check_val("rst_terr", 32'(bus.timeout_err), 0);
        check_val("rst_pulses", 32'(bus.pulses_sent), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Normal three-pulse burst.
        run_burst(3, -1, 1'b0);
        check_val("t1_ack_cyc", ack_first, 1);
        check_val("t1_n_start", start_cyc.size(), 3);
        check_val("t1_start0", q_at(start_cyc, 0), 1);
        check_val("t1_start1", q_at(start_cyc, 1), 6);
        check_val("t1_start2", q_at(start_cyc, 2), 11);
        check_val("t1_echo2", q_at(echo_cyc, 2), 16);
        check_val("t1_done_cyc", done_cyc, 17);
        check_val("t1_pulses", 32'(bus.pulses_sent), 3);
        check_val("t1_terr", 32'(bus.timeout_err), 0);
        repeat (2) @(negedge clk);

        // Zero-length burst.
        run_burst(0, -1, 1'b0);
        check_val("t2_ack_cyc", ack_first, 1);
        check_val("t2_done_cyc", done_cyc, 1);
        check_val("t2_n_start", start_cyc.size(), 0);
        check_val("t2_pulses", 32'(bus.pulses_sent), 0);
        repeat (2) @(negedge clk);

        // Echo suppressed: drain timeout.
        echo_en = 1'b0;
        run_burst(1, -1, 1'b0);
        check_val("t3_n_start", start_cyc.size(), 1);
        check_val("t3_done_cyc", done_cyc, 18);
        check_val("t3_terr", 32'(bus.timeout_err), 1);
        repeat (2) @(negedge clk);
        check_val("t3_terr_sticky", 32'(bus.timeout_err), 1);
        echo_en = 1'b1;
        run_burst(1, -1, 1'b0);
        check_val("t3_terr_cleared", terr_at_ack, 0);
        check_val("t3_done_cyc2", done_cyc, 7);
        check_val("t3_terr_after", 32'(bus.timeout_err), 0);
        repeat (2) @(negedge clk);

        // Abort in the first gap; the late echo must not wake anything up.
        run_burst(4, 3, 1'b0);
        check_val("t4_n_start", start_cyc.size(), 1);
        check_val("t4_done_cyc", done_cyc, 4);
        check_val("t4_pulses", 32'(bus.pulses_sent), 1);
        check_val("t4_terr", 32'(bus.timeout_err), 0);
        watch(8);
        check_val("t4_late_echo", w_echo, 1);
        check_val("t4_idle_busy", w_busy, 0);
        check_val("t4_idle_done", w_done, 0);
        check_val("t4_pulses_kept", 32'(bus.pulses_sent), 1);

        // Request held high throughout, then req+abort in idle.
        run_burst(2, -1, 1'b1);
        check_val("t5_ack_count", ack_cnt, 1);
        check_val("t5_done_cyc", done_cyc, 12);
        check_val("t5_pulses", 32'(bus.pulses_sent), 2);
        @(negedge clk);
        bus.req   = 1'b1;
        bus.abort = 1'b1;
        watch(4);
        bus.req   = 1'b0;
        bus.abort = 1'b0;
        check_val("t5_abort_ack", w_ack, 0);
        check_val("t5_abort_busy", w_busy, 0);
        check_val("t5_abort_start", w_start, 0);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a gap.
        bus.burst_len = 8'd5;
        bus.req       = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        repeat (2) @(negedge clk);
        check_val("t6_pre_busy", 32'(bus.busy), 1);
        check_val("t6_pre_pulses", 32'(bus.pulses_sent), 1);
        #2 reset = 1'b1;
        #1;
        check_val("t6_rst_start", 32'(bus.start), 0);
        check_val("t6_rst_busy", 32'(bus.busy), 0);
        check_val("t6_rst_ack", 32'(bus.ack), 0);
        check_val("t6_rst_done", 32'(bus.done), 0);
        check_val("t6_rst_terr", 32'(bus.timeout_err), 0);
        check_val("t6_rst_pulses", 32'(bus.pulses_sent), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_burst(2, -1, 1'b0);
        check_val("t6_ack_cyc", ack_first, 1);
        check_val("t6_n_start", start_cyc.size(), 2);
        check_val("t6_start1", q_at(start_cyc, 1), 6);
        check_val("t6_done_cyc", done_cyc, 12);
        check_val("t6_pulses", 32'(bus.pulses_sent), 2);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
